// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: state encoding, fixed opcodes and the user-chain opcode range check.
// Used by jtag_tap_fsm and jtag_tap_mchain.
package jtag_tap_pkg;

   typedef enum logic [3:0] {
      TLR    = 4'h0,
      RTI    = 4'h1,
      SEL_DR = 4'h2,
      CAP_DR = 4'h3,
      SH_DR  = 4'h4,
      EX1_DR = 4'h5,
      PAU_DR = 4'h6,
      EX2_DR = 4'h7,
      UPD_DR = 4'h8,
      SEL_IR = 4'h9,
      CAP_IR = 4'hA,
      SH_IR  = 4'hB,
      EX1_IR = 4'hC,
      PAU_IR = 4'hD,
      EX2_IR = 4'hE,
      UPD_IR = 4'hF
   } tap_states;

   typedef enum logic [2:0] {
      FOP_EXTEST,
      FOP_SAMPLE_PRELOAD,
      FOP_IDCODE,
      FOP_USERCODE,
      FOP_BYPASS
   } fixed_op_e;

   function automatic logic [7:0] fixed_opcode(input fixed_op_e op, input int ir_bits);
      logic [7:0] code;
      case (op)
         FOP_EXTEST:         code = 8'd0;
         FOP_SAMPLE_PRELOAD: code = 8'd1;
         FOP_IDCODE:         code = 8'd2;
         FOP_USERCODE:       code = 8'd6;
         default:            code = 8'((1 << ir_bits) - 1);
      endcase
      return code;
   endfunction

   // Every chain opcode must fit the IR and must not alias a fixed opcode.
   function automatic bit user_range_ok(input int ir_bits, input int chains, input int base);
      bit ok;
      int op;
      ok = 1'b1;
      for (int i = 0; i < chains; i++) begin
         op = base + i;
         if (op >= (1 << ir_bits) || op == 0 || op == 1 || op == 2 || op == 6 ||
             op == (1 << ir_bits) - 1)
            ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller; the state register is exported as-is for debug visibility.
module jtag_tap_fsm
   import jtag_tap_pkg::*;
(
   input  logic       tck,
   input  logic       tap_resetn,
   input  logic       tms,
   output logic [3:0] state
);

   tap_states cur_state, nxt_state;

   always_ff @(posedge tck or negedge tap_resetn) begin
      if (!tap_resetn) cur_state <= TLR;
      else             cur_state <= nxt_state;
   end

   always_comb begin
      nxt_state = TLR;
      case (cur_state)
         TLR:    nxt_state = tms ? TLR    : RTI;
         RTI:    nxt_state = tms ? SEL_DR : RTI;
         SEL_DR: nxt_state = tms ? SEL_IR : CAP_DR;
         CAP_DR: nxt_state = tms ? EX1_DR : SH_DR;
         SH_DR:  nxt_state = tms ? EX1_DR : SH_DR;
         EX1_DR: nxt_state = tms ? UPD_DR : PAU_DR;
         PAU_DR: nxt_state = tms ? EX2_DR : PAU_DR;
         EX2_DR: nxt_state = tms ? UPD_DR : SH_DR;
         UPD_DR: nxt_state = tms ? SEL_DR : RTI;
         SEL_IR: nxt_state = tms ? TLR    : CAP_IR;
         CAP_IR: nxt_state = tms ? EX1_IR : SH_IR;
         SH_IR:  nxt_state = tms ? EX1_IR : SH_IR;
         EX1_IR: nxt_state = tms ? UPD_IR : PAU_IR;
         PAU_IR: nxt_state = tms ? EX2_IR : PAU_IR;
         EX2_IR: nxt_state = tms ? UPD_IR : SH_IR;
         UPD_IR: nxt_state = tms ? SEL_DR : RTI;
         default: nxt_state = TLR;
      endcase
   end

   assign state = cur_state;

endmodule

// File: rtl/jtag_tap_mchain.sv
// Parametrised TAP with IR, BYPASS/IDCODE registers and up to eight user debug chains.
// Define JTAG_TAP_USERCODE_EN to include the USERCODE register (opcode 6); otherwise 6 decodes to BYPASS.
module jtag_tap_mchain
   import jtag_tap_pkg::*;
#(
   parameter int          IR_BITS       = 4,
   parameter int          CHAINS        = 2,
   parameter logic [31:0] JTAG_IDCODE   = 32'h000009DD,
   parameter logic [31:0] JTAG_USERCODE = 32'h0,
   parameter int          USER_BASE     = 8
)(
   input  logic                jtag_tck,
   input  logic                tap_resetn,
   input  logic                jtag_tms,
   input  logic                jtag_tdi,
   output logic                jtag_tdo,
   output logic                jtag_tdo_oe,
   input  logic [IR_BITS-3:0]  ir_status,
   output logic [3:0]          tap_state_o,
   output logic [CHAINS-1:0]   chain_sel,
   output logic                chain_capture,
   output logic                chain_shift,
   output logic                chain_update,
   output logic                chain_tdi,
   input  logic [CHAINS-1:0]   chain_tdo
);

   if (IR_BITS < 2 || IR_BITS > 8 || CHAINS < 1 || CHAINS > 8 || !JTAG_IDCODE[0] ||
       !user_range_ok(IR_BITS, CHAINS, USER_BASE)) begin : g_bad_params
      $error("jtag_tap_mchain: illegal IR_BITS/CHAINS/JTAG_IDCODE/USER_BASE combination");
   end

   localparam logic [IR_BITS-1:0] OP_IDCODE = IR_BITS'(fixed_opcode(FOP_IDCODE, IR_BITS));

   logic [3:0]         state_bits;
   tap_states          state;
   logic [IR_BITS-1:0] ir_shift;
   logic [IR_BITS-1:0] instr;
   logic               bypass_reg;
   logic [31:0]        idcode_sr;
   logic               sel_idcode;
   logic               shifting;
   logic               tdo_next;

   jtag_tap_fsm u_fsm (
      .tck        (jtag_tck),
      .tap_resetn (tap_resetn),
      .tms        (jtag_tms),
      .state      (state_bits)
   );

   assign state       = tap_states'(state_bits);
   assign tap_state_o = state_bits;
   assign shifting    = (state == SH_IR) || (state == SH_DR);
   assign sel_idcode  = (instr == OP_IDCODE);
   assign chain_tdi   = jtag_tdi;

   always_ff @(posedge jtag_tck or negedge tap_resetn) begin
      if (!tap_resetn)            ir_shift <= '0;
      else if (state == CAP_IR)   ir_shift <= {ir_status, 2'b01};
      else if (state == SH_IR)    ir_shift <= {jtag_tdi, ir_shift[IR_BITS-1:1]};
   end

   // Updated on the falling edge so chain_sel settles half a cycle before the next capture.
   always_ff @(negedge jtag_tck or negedge tap_resetn) begin
      if (!tap_resetn)            instr <= OP_IDCODE;
      else if (state == TLR)      instr <= OP_IDCODE;
      else if (state == UPD_IR)   instr <= ir_shift;
   end

   always_comb begin
      chain_sel = '0;
      for (int i = 0; i < CHAINS; i++)
         chain_sel[i] = (instr == IR_BITS'(USER_BASE + i));
   end

   assign chain_capture = (state == CAP_DR) && (|chain_sel);
   assign chain_shift   = (state == SH_DR)  && (|chain_sel);
   assign chain_update  = (state == UPD_DR) && (|chain_sel);

   always_ff @(posedge jtag_tck or negedge tap_resetn) begin
      if (!tap_resetn)            bypass_reg <= 1'b0;
      else if (state == CAP_DR)   bypass_reg <= 1'b0;
      else if (state == SH_DR)    bypass_reg <= jtag_tdi;
   end

   always_ff @(posedge jtag_tck or negedge tap_resetn) begin
      if (!tap_resetn)                          idcode_sr <= JTAG_IDCODE;
      else if (state == TLR || state == CAP_DR) idcode_sr <= JTAG_IDCODE;
      else if (state == SH_DR && sel_idcode)    idcode_sr <= {jtag_tdi, idcode_sr[31:1]};
   end

`ifdef JTAG_TAP_USERCODE_EN
   localparam logic [IR_BITS-1:0] OP_USERCODE = IR_BITS'(fixed_opcode(FOP_USERCODE, IR_BITS));

   logic [31:0] usercode_sr;
   logic        sel_user;

   assign sel_user = (instr == OP_USERCODE);

   always_ff @(posedge jtag_tck or negedge tap_resetn) begin
      if (!tap_resetn)                          usercode_sr <= JTAG_USERCODE;
      else if (state == TLR || state == CAP_DR) usercode_sr <= JTAG_USERCODE;
      else if (state == SH_DR && sel_user)      usercode_sr <= {jtag_tdi, usercode_sr[31:1]};
   end
`else
   logic unused_usercode;
   assign unused_usercode = ^JTAG_USERCODE;
`endif

   // Data registers are mutually exclusive; anything unrecognised falls through to BYPASS.
   always_comb begin
      tdo_next = bypass_reg;
      if (sel_idcode) tdo_next = idcode_sr[0];
`ifdef JTAG_TAP_USERCODE_EN
      if (sel_user)   tdo_next = usercode_sr[0];
`endif
      for (int i = 0; i < CHAINS; i++)
         if (chain_sel[i]) tdo_next = chain_tdo[i];
      if (state == SH_IR) tdo_next = ir_shift[0];
   end

   always_ff @(negedge jtag_tck or negedge tap_resetn) begin
      if (!tap_resetn) begin
         jtag_tdo    <= 1'b0;
         jtag_tdo_oe <= 1'b0;
      end else begin
         jtag_tdo_oe <= shifting;
         if (shifting) jtag_tdo <= tdo_next;
      end
   end

endmodule

// File: tb/tb_jtag_tap_mchain.sv
// Bench for jtag_tap_mchain: TMS/TDI drivers, a TDO scoreboard fed by expected bits, per-feature tests.
`timescale 1ns/1ps
module tb_jtag_tap_mchain;
   import jtag_tap_pkg::*;

   localparam int          IR_BITS      = 4;
   localparam int          CHAINS       = 2;
   localparam logic [31:0] IDCODE_VAL   = 32'h000009DD;
   localparam logic [31:0] USERCODE_VAL = 32'h0;
   localparam int          W            = 1;

   logic                jtag_tck   = 1'b0;
   logic                tap_resetn = 1'b0;
   logic                jtag_tms   = 1'b1;
   logic                jtag_tdi   = 1'b0;
   logic                jtag_tdo, jtag_tdo_oe;
   logic [IR_BITS-3:0]  ir_status  = '0;
   logic [3:0]          tap_state_o;
   logic [CHAINS-1:0]   chain_sel;
   logic                chain_capture, chain_shift, chain_update, chain_tdi;
   logic [CHAINS-1:0]   chain_tdo  = '0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_bit;
   int checks   = 0;
   int failures = 0;
   int cap_cnt  = 0;
   int sh_cnt   = 0;
   int upd_cnt  = 0;

   jtag_tap_mchain #(
      .IR_BITS(IR_BITS), .CHAINS(CHAINS), .JTAG_IDCODE(IDCODE_VAL),
      .JTAG_USERCODE(USERCODE_VAL), .USER_BASE(8)
   ) dut (
      .jtag_tck(jtag_tck), .tap_resetn(tap_resetn), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
      .jtag_tdo(jtag_tdo), .jtag_tdo_oe(jtag_tdo_oe), .ir_status(ir_status),
      .tap_state_o(tap_state_o), .chain_sel(chain_sel), .chain_capture(chain_capture),
      .chain_shift(chain_shift), .chain_update(chain_update), .chain_tdi(chain_tdi),
      .chain_tdo(chain_tdo)
   );

   // ---------------- clock / watchdog ----------------
   always #5 jtag_tck = ~jtag_tck;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- scoreboard: every enabled TDO bit is compared to the queue head ----------------
   always @(negedge jtag_tck) begin
      #1;
      if (jtag_tdo_oe === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL tdo_sb: tdo=%b driven with oe=1 but no expected bit queued", jtag_tdo);
         end else begin
            exp_bit = exp_q.pop_front();
            if (jtag_tdo !== exp_bit) begin
               failures++;
               $display("FAIL tdo_sb: tdo=%b expected %b (state %0h)", jtag_tdo, exp_bit, tap_state_o);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clk(input logic tms, input logic tdi);
      jtag_tms = tms;
      jtag_tdi = tdi;
      @(posedge jtag_tck);
      @(negedge jtag_tck);
      #1;
      if (chain_capture) cap_cnt++;
      if (chain_shift)   sh_cnt++;
      if (chain_update)  upd_cnt++;
   endtask

   // Enters Shift from Capture/Exit2 and shifts n bits, leaving the TAP in Exit1.
   task automatic shift_seq(input int n, input logic [63:0] tdi_v, input logic [63:0] ctdo_v);
      chain_tdo = {ctdo_v[0], ~ctdo_v[0]};
      clk(1'b0, 1'b0);
      for (int k = 0; k < n; k++) begin
         if (k < n - 1) chain_tdo = {ctdo_v[k+1], ~ctdo_v[k+1]};
         clk(logic'(k == n - 1), tdi_v[k]);
      end
   endtask

   task automatic scan_dr(input int n, input logic [63:0] tdi_v, input logic [63:0] ctdo_v);
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
      shift_seq(n, tdi_v, ctdo_v);
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
   endtask

   task automatic push_ir_capture();
      logic [IR_BITS-1:0] cap;
      cap = {ir_status, 2'b01};
      for (int k = 0; k < IR_BITS; k++) exp_q.push_back(cap[k]);
   endtask

   task automatic scan_ir(input logic [IR_BITS-1:0] opcode);
      push_ir_capture();
      clk(1'b1, 1'b0);
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
      shift_seq(IR_BITS, 64'(opcode), 64'($urandom));
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
   endtask

   task automatic push_word(input logic [31:0] v, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(v[k]);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clk(1'b1, 1'b0);
      clk(1'b1, 1'b0);
      checks++;
      if (tap_state_o !== 4'(TLR)) begin failures++; $display("FAIL reset_state: got %0h want %0h", tap_state_o, 4'(TLR)); end
      checks++;
      if ({jtag_tdo, jtag_tdo_oe} !== 2'b00) begin failures++; $display("FAIL reset_tdo: tdo/oe=%b want 00", {jtag_tdo, jtag_tdo_oe}); end
      checks++;
      if ({chain_sel, chain_capture, chain_shift, chain_update} !== '0) begin
         failures++; $display("FAIL reset_chain: sel=%b strobes=%b want all 0", chain_sel, {chain_capture, chain_shift, chain_update});
      end
      tap_resetn = 1'b1;
      clk(1'b0, 1'b0);
      checks++;
      if (tap_state_o !== 4'(RTI)) begin failures++; $display("FAIL reset_to_rti: got %0h want %0h", tap_state_o, 4'(RTI)); end
   endtask

   task automatic test_idcode();
      push_word(IDCODE_VAL, 32);
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
      shift_seq(32, {$urandom, $urandom}, {$urandom, $urandom});
      checks++;
      if (jtag_tdo_oe !== 1'b0 || jtag_tdo !== IDCODE_VAL[31]) begin
         failures++; $display("FAIL idcode_exit: oe=%b tdo=%b want oe=0 tdo=%b", jtag_tdo_oe, jtag_tdo, IDCODE_VAL[31]);
      end
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL idcode_len: %0d bits unseen want 0", exp_q.size()); end
   endtask

   task automatic test_ir_capture();
      ir_status = 2'b10;
      scan_ir(4'h2);
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL ir_capture_len: %0d bits unseen want 0", exp_q.size()); end
      ir_status = 2'($urandom_range(0, 3));
      scan_ir(4'hF);
      checks++;
      if (tap_state_o !== 4'(RTI)) begin failures++; $display("FAIL ir_scan_end: got %0h want %0h", tap_state_o, 4'(RTI)); end
   endtask

   task automatic test_bypass();
      logic [8:0] tdi_v;
      tdi_v = {1'b0, 8'hA5};
      cap_cnt = 0; sh_cnt = 0; upd_cnt = 0;
      exp_q.push_back(1'b0);
      for (int k = 0; k < 8; k++) exp_q.push_back(tdi_v[k]);
      scan_dr(9, 64'(tdi_v), {$urandom, $urandom});
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL bypass_len: %0d bits unseen want 0", exp_q.size()); end
      checks++;
      if (cap_cnt + sh_cnt + upd_cnt != 0) begin failures++; $display("FAIL bypass_strobes: %0d strobe cycles want 0", cap_cnt + sh_cnt + upd_cnt); end
   endtask

   task automatic test_chain();
      int n;
      logic [63:0] ctdo_v;
      scan_ir(4'h9);
      checks++;
      if (chain_sel !== 2'b10) begin failures++; $display("FAIL chain_sel: got %b want 10", chain_sel); end
      n = $urandom_range(4, 12);
      ctdo_v = {$urandom, $urandom};
      for (int k = 0; k < n; k++) exp_q.push_back(ctdo_v[k]);
      cap_cnt = 0; sh_cnt = 0; upd_cnt = 0;
      scan_dr(n, {$urandom, $urandom}, ctdo_v);
      checks++;
      if (cap_cnt != 1 || sh_cnt != n || upd_cnt != 1) begin
         failures++; $display("FAIL chain_strobes: cap=%0d sh=%0d upd=%0d want 1 %0d 1", cap_cnt, sh_cnt, upd_cnt, n);
      end
      jtag_tdi = 1'b1;
      #1;
      checks++;
      if (chain_tdi !== 1'b1) begin failures++; $display("FAIL chain_tdi: got %b want 1", chain_tdi); end
      jtag_tdi = 1'b0;
   endtask

   task automatic test_unused_opcode();
      logic [7:0] b;
      scan_ir(4'h4);
      checks++;
      if (chain_sel !== 2'b00) begin failures++; $display("FAIL unused_sel: got %b want 00", chain_sel); end
      b = 8'($urandom);
      exp_q.push_back(1'b0);
      for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
      scan_dr(9, 64'({1'b0, b}), 64'($urandom));
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL unused_len: %0d bits unseen want 0", exp_q.size()); end
      for (int k = 0; k < 5; k++) clk(1'b1, 1'b0);
      checks++;
      if (tap_state_o !== 4'(TLR) || chain_sel !== 2'b00) begin
         failures++; $display("FAIL tms_reset: state=%0h sel=%b want 0 00", tap_state_o, chain_sel);
      end
      clk(1'b0, 1'b0);
      push_word(IDCODE_VAL, 32);
      scan_dr(32, 64'($urandom), 64'($urandom));
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL tlr_idcode_len: %0d bits unseen want 0", exp_q.size()); end
   endtask

   task automatic test_usercode();
      logic [7:0] b;
      scan_ir(4'h6);
`ifdef JTAG_TAP_USERCODE_EN
      b = 8'h0;
      push_word(USERCODE_VAL, 32);
      scan_dr(32, {$urandom, $urandom}, 64'($urandom));
`else
      b = 8'($urandom);
      exp_q.push_back(1'b0);
      for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
      scan_dr(9, 64'({1'b0, b}), 64'($urandom));
`endif
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL usercode_len: %0d bits unseen want 0 (b=%h)", exp_q.size(), b); end
   endtask

   task automatic test_back_to_back();
      scan_ir(4'h2);
      push_word(IDCODE_VAL, 32);
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
      shift_seq(16, 64'($urandom), 64'($urandom));
      clk(1'b0, 1'b0);
      clk(1'b0, 1'b0);
      checks++;
      if (tap_state_o !== 4'(PAU_DR) || jtag_tdo_oe !== 1'b0) begin
         failures++; $display("FAIL pause: state=%0h oe=%b want %0h 0", tap_state_o, jtag_tdo_oe, 4'(PAU_DR));
      end
      clk(1'b1, 1'b0);
      shift_seq(16, 64'($urandom), 64'($urandom));
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL pause_resume_len: %0d bits unseen want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_shift();
      scan_ir(4'h9);
      chain_tdo = 2'b10;
      for (int k = 0; k < 4; k++) exp_q.push_back(1'b1);
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
      for (int k = 0; k < 4; k++) clk(1'b0, 1'($urandom));
      upd_cnt = 0;
      #2 tap_resetn = 1'b0;
      #1;
      checks++;
      if (tap_state_o !== 4'(TLR) || {jtag_tdo, jtag_tdo_oe} !== 2'b00 || chain_sel !== 2'b00 ||
          {chain_capture, chain_shift, chain_update} !== 3'b000) begin
         failures++;
         $display("FAIL mid_shift_reset: state=%0h tdo/oe=%b sel=%b strobes=%b want 0 00 00 000",
                  tap_state_o, {jtag_tdo, jtag_tdo_oe}, chain_sel, {chain_capture, chain_shift, chain_update});
      end
      clk(1'b1, 1'b0);
      clk(1'b1, 1'b0);
      tap_resetn = 1'b1;
      clk(1'b0, 1'b0);
      checks++;
      if (upd_cnt != 0 || chain_sel !== 2'b00 || tap_state_o !== 4'(RTI)) begin
         failures++; $display("FAIL post_reset: upd=%0d sel=%b state=%0h want 0 00 %0h", upd_cnt, chain_sel, tap_state_o, 4'(RTI));
      end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL mid_shift_len: %0d bits unseen want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_idcode();
      test_ir_capture();
      test_bypass();
      test_chain();
      test_unused_opcode();
      test_usercode();
      test_back_to_back();
      test_reset_mid_shift();
      repeat (2) @(negedge jtag_tck);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
